// File: rtl/vec_issue_sequencer_if.sv
// vec_issue_sequencer_if: issue, datapath-control and memory handshake bundle for vec_issue_sequencer
interface vec_issue_sequencer_if #(
    parameter int LANES   = 4,
    parameter int VREG_AW = 5
);
    logic               issue_valid;
    logic               issue_ready;
    logic [1:0]         issue_op;
    logic [VREG_AW-1:0] issue_vd;
    logic [2:0]         issue_nregs;
    logic               issue_masked;
    logic [LANES-1:0]   lane_mask;
    logic [LANES-1:0]   VWEn;
    logic               VWBSel;
    logic [VREG_AW-1:0] vreg_idx;
    logic               mem_req;
    logic               mem_we;
    logic               mem_ack;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output issue_valid, issue_op, issue_vd, issue_nregs, issue_masked, lane_mask, mem_ack,
        input  issue_ready, VWEn, VWBSel, vreg_idx, mem_req, mem_we, busy, done, err
    );

    modport slave (
        input  issue_valid, issue_op, issue_vd, issue_nregs, issue_masked, lane_mask, mem_ack,
        output issue_ready, VWEn, VWBSel, vreg_idx, mem_req, mem_we, busy, done, err
    );
endinterface

// File: rtl/vec_issue_sequencer.sv
// vec_issue_sequencer: per-beat vector register group sequencer; VSEQ_TIMEOUT_EN enables the memory watchdog
module vec_issue_sequencer #(
    parameter int LANES     = 4,
    parameter int VREG_AW   = 5,
    parameter int MAX_GROUP = 4,
    parameter int TIMEOUT   = 64
) (
    input logic                 clk,
    input logic                 rst,
    vec_issue_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, EXEC, MREQ, MWB, DONE} state_t;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [2:0] MAXG     = 3'(MAX_GROUP);

    state_t             state, next;
    logic [1:0]         op_q;
    logic [VREG_AW-1:0] vd_q;
    logic [2:0]         nregs_q;
    logic [LANES-1:0]   em_q;
    logic [2:0]         beat;
    logic               last;
    logic               tmo;
    logic               take;
    logic [2:0]         n_eff;

    assign take  = bus.issue_valid && state == IDLE;
    assign last  = beat == nregs_q - 3'd1;
    assign n_eff = bus.issue_nregs == 3'd0 ? 3'd1 : bus.issue_nregs > MAXG ? MAXG : bus.issue_nregs;

`ifdef VSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    // Watchdog: counts consecutive ack-less MREQ cycles, restarting on every ack and on MREQ entry
    always_ff @(posedge clk) begin
        if (rst || state != MREQ || bus.mem_ack) tcnt <= '0;
        else tcnt <= tcnt + 1'b1;
    end

    assign tmo = state == MREQ && !bus.mem_ack && tcnt == TW'(TIMEOUT - 1);
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT != 0;
    assign tmo = 1'b0;
`endif

    // State register, descriptor latch and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            vd_q    <= '0;
            nregs_q <= '0;
            em_q    <= '0;
            beat    <= '0;
        end else begin
            state <= next;
            if (take) begin
                op_q    <= bus.issue_op;
                vd_q    <= bus.issue_vd;
                nregs_q <= n_eff;
                em_q    <= bus.issue_masked ? bus.lane_mask : '1;
                beat    <= '0;
            end else if (state == EXEC || state == MWB || (state == MREQ && bus.mem_ack && op_q == OP_STORE)) begin
                beat <= beat + 3'd1;
            end
        end
    end

    // Next-state: loads take an MWB beat after each ack, stores advance straight to the next MREQ
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !take ? IDLE : (bus.issue_op == OP_LOAD || bus.issue_op == OP_STORE) ? MREQ : EXEC;
            EXEC:    next = last ? DONE : EXEC;
            MREQ:    next = bus.mem_ack ? (op_q == OP_LOAD ? MWB : last ? DONE : MREQ) : tmo ? DONE : MREQ;
            MWB:     next = last ? DONE : MREQ;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Datapath and memory controls decoded from the current state
    always_comb begin
        bus.issue_ready = state == IDLE;
        bus.busy        = state != IDLE;
        bus.VWEn        = (state == EXEC || state == MWB) ? em_q : '0;
        bus.VWBSel      = state == MWB;
        bus.vreg_idx    = (state == EXEC || state == MREQ || state == MWB) ? vd_q + VREG_AW'(beat) : '0;
        bus.mem_req     = state == MREQ;
        bus.mem_we      = state == MREQ && op_q == OP_STORE;
        bus.done        = state == DONE;
        bus.err         = tmo;
    end
endmodule
